// File: rtl/mem_stage_pkg.sv
// Shared constants and decode helpers for the MEM stage.
package mem_stage_pkg;

  // Opcodes seen by the MEM stage.
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Load/store width codes carried in funct3.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access FSM: idle, or waiting for the data memory to acknowledge.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    W_BYTE = 2'd0,
    W_HALF = 2'd1,
    W_WORD = 2'd2
  } width_t;

  // Access width; any funct3 that is not a defined code is treated as a word.
  function automatic width_t access_width(input logic [2:0] funct3, input logic is_load);
    width_t w;
    case (funct3)
      F3_LB:   w = W_BYTE;
      F3_LH:   w = W_HALF;
      F3_LBU:  w = is_load ? W_BYTE : W_WORD;
      F3_LHU:  w = is_load ? W_HALF : W_WORD;
      default: w = W_WORD;
    endcase
    return w;
  endfunction

  function automatic logic is_aligned(input width_t w, input logic [1:0] addr_lo);
    case (w)
      W_BYTE:  return 1'b1;
      W_HALF:  return !addr_lo[0];
      default: return addr_lo == 2'b00;
    endcase
  endfunction

  // Instruction classes that write a destination register.
  function automatic logic writes_rd(input logic [6:0] opcode);
    return opcode inside {OPC_LOAD, OPC_OP, OPC_OP_IMM, OPC_LUI,
                          OPC_AUIPC, OPC_JAL, OPC_JALR};
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/ack bus between the MEM stage and data memory.
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/half out of a load word and extends it.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  // Extend the selected lane according to the load type.
  always_comb begin
    // NOTE: o_data gets a value on every path (default arm below), so no latch is inferred.
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {24'h0, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_data = {16'h0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues loads/stores on the dmem bus, stalls while an access is
// outstanding, and registers the MEM/WB payload.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  input  logic [31:0]       alu_out_i,
  input  logic [31:0]       store_data_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [4:0]        rd_i,
  output logic              stall_o,
  mem_stage_if.master       dmem,
  output logic              wb_valid_o,
  output logic              wb_we_o,
  output logic [4:0]        wb_rd_o,
  output logic [31:0]       wb_data_o,
  output logic              misalign_o,
  output logic              bus_err_o
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [4:0]  r_rd;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic        r_is_load;
  logic [31:0] r_alu;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_mem_op;
  width_t      w_width;
  logic        w_aligned;
  logic        w_start;
  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

  assign w_is_load  = ex_valid_i && (opcode_i == OPC_LOAD);
  assign w_is_store = ex_valid_i && (opcode_i == OPC_STORE);
  assign w_mem_op   = w_is_load || w_is_store;
  assign w_width    = access_width(funct3_i, w_is_load);
  assign w_aligned  = is_aligned(w_width, alu_out_i[1:0]);
  assign w_start    = w_mem_op && w_aligned;
  assign w_misalign = w_mem_op && !w_aligned;

  // Hold upstream while a request is being launched or is still waiting.
  assign stall_o = !rst &&
                   (((r_state == ST_IDLE) && w_start) ||
                    ((r_state == ST_WAIT) && !dmem.ack && (r_cnt < MAX_CNT)));

  // Store byte enables and lane-replicated write data; loads drive no enables.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = store_data_i;
    if (w_is_store) begin
      case (w_width)
        W_BYTE: begin
          w_be    = 4'b0001 << alu_out_i[1:0];
          w_wdata = {4{store_data_i[7:0]}};
        end
        W_HALF: begin
          w_be    = 4'b0011 << {alu_out_i[1], 1'b0};
          w_wdata = {2{store_data_i[15:0]}};
        end
        default: w_be = 4'b1111;
      endcase
    end
  end

  mem_stage_load_align u_load_align (
    .i_rdata   (dmem.rdata),
    .i_addr_lo (r_addr_lo),
    .i_funct3  (r_funct3),
    .o_data    (w_load_data)
  );

  // Access FSM, wait counter, dmem request registers and MEM/WB payload.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments, so every register here updates from pre-edge values.
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 8'd0;
      r_rd       <= 5'd0;
      r_funct3   <= 3'd0;
      r_addr_lo  <= 2'd0;
      r_is_load  <= 1'b0;
      r_alu      <= 32'd0;
      dmem.req   <= 1'b0;
      dmem.we    <= 1'b0;
      dmem.addr  <= 32'd0;
      dmem.wdata <= 32'd0;
      dmem.be    <= 4'd0;
      wb_valid_o <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_rd_o    <= 5'd0;
      wb_data_o  <= 32'd0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      // Pulses and the WB slot default to idle; a stall cycle sends a bubble.
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      wb_valid_o <= 1'b0;
      wb_we_o    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state    <= ST_WAIT;
            r_cnt      <= 8'd0;
            r_rd       <= rd_i;
            r_funct3   <= funct3_i;
            r_addr_lo  <= alu_out_i[1:0];
            r_is_load  <= w_is_load;
            r_alu      <= alu_out_i;
            dmem.req   <= 1'b1;
            dmem.we    <= w_is_store;
            dmem.addr  <= {alu_out_i[31:2], 2'b00};
            dmem.wdata <= w_wdata;
            dmem.be    <= w_be;
          end else begin
            // Non-mem instruction, bubble, or a dropped misaligned access.
            wb_valid_o <= ex_valid_i;
            wb_rd_o    <= rd_i;
            wb_data_o  <= alu_out_i;
            wb_we_o    <= ex_valid_i && !w_misalign && writes_rd(opcode_i) && (rd_i != 5'd0);
            misalign_o <= w_misalign;
          end
        end
        ST_WAIT: begin
          if (dmem.ack) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 8'd0;
            dmem.req   <= 1'b0;
            wb_valid_o <= 1'b1;
            wb_rd_o    <= r_rd;
            wb_data_o  <= r_is_load ? w_load_data : r_alu;
            wb_we_o    <= r_is_load && (r_rd != 5'd0);
          end else if (r_cnt == MAX_CNT) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 8'd0;
            dmem.req   <= 1'b0;
            wb_valid_o <= 1'b1;
            wb_rd_o    <= r_rd;
            wb_data_o  <= 32'd0;
            bus_err_o  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage with MAX_WAIT=4.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] alu_out;
  logic [31:0] store_data;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        stall;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;
  logic        bus_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage_if u_if ();

  mem_stage #(.MAX_WAIT(4)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid_i   (ex_valid),
    .alu_out_i    (alu_out),
    .store_data_i (store_data),
    .opcode_i     (opcode),
    .funct3_i     (funct3),
    .rd_i         (rd),
    .stall_o      (stall),
    .dmem         (u_if.master),
    .wb_valid_o   (wb_valid),
    .wb_we_o      (wb_we),
    .wb_rd_o      (wb_rd),
    .wb_data_o    (wb_data),
    .misalign_o   (misalign),
    .bus_err_o    (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r);
    ex_valid   = v;
    opcode     = opc;
    funct3     = f3;
    alu_out    = a;
    store_data = sd;
    rd         = r;
  endtask

  task automatic bubble();
    set_instr(1'b0, OPC_OP, 3'd0, 32'd0, 32'd0, 5'd0);
  endtask

  // Present one mem op, ack on request cycle 'delay' (-1 = never), count stall
  // cycles, record the bus request and check it stays stable while held.
  // Returns just after the retiring edge with a bubble presented.
  task automatic mem_access(input logic [6:0] opc, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd,
                            input logic [4:0] r, input int delay,
                            input logic [31:0] rdata,
                            output int stalls, output int req_cycles,
                            output logic [31:0] q_addr, output logic [31:0] q_wdata,
                            output logic [3:0] q_be, output logic q_we);
    logic done;
    stalls     = 0;
    req_cycles = 0;
    done       = 1'b0;
    q_addr = '0; q_wdata = '0; q_be = '0; q_we = 1'b0;
    set_instr(1'b1, opc, f3, a, sd, r);
    for (int c = 0; c < 40; c++) begin
      u_if.ack   = u_if.req && (req_cycles == delay);
      u_if.rdata = u_if.ack ? rdata : 32'hDEAD_BEEF;
      #1;
      if (u_if.req) begin
        if (req_cycles == 0) begin
          q_addr = u_if.addr; q_wdata = u_if.wdata; q_be = u_if.be; q_we = u_if.we;
        end else begin
          check("hold_addr", u_if.addr, q_addr);
          check("hold_be", {28'd0, u_if.be}, {28'd0, q_be});
        end
        req_cycles++;
      end
      if (!stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
      tick();
    end
    if (!done) check("stall_bound", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    u_if.ack   = 1'b0;
    u_if.rdata = 32'd0;
    bubble();
  endtask

  int          st;
  int          rc;
  logic [31:0] qa;
  logic [31:0] qw;
  logic [3:0]  qb;
  logic        qe;

  initial begin
    rst        = 1'b1;
    u_if.ack   = 1'b0;
    u_if.rdata = 32'd0;
    bubble();
    tick();
    tick();

    // Reset state.
    check("rst_req", {31'd0, u_if.req}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_wb_we", {31'd0, wb_we}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_err", {30'd0, misalign, bus_err}, 32'd0);
    rst = 1'b0;

    // ADD rd=5: one-cycle latency, no stall.
    set_instr(1'b1, OPC_OP, 3'd0, 32'h0000_1234, 32'd0, 5'd5);
    #1;
    check("add_stall", {31'd0, stall}, 32'd0);
    tick();
    check("add_data", wb_data, 32'h0000_1234);
    check("add_we", {31'd0, wb_we}, 32'd1);
    check("add_rd", {27'd0, wb_rd}, 32'd5);
    check("add_valid", {31'd0, wb_valid}, 32'd1);
    // Same with rd=0: no register write.
    set_instr(1'b1, OPC_OP, 3'd0, 32'h0000_1234, 32'd0, 5'd0);
    tick();
    check("add_rd0_we", {31'd0, wb_we}, 32'd0);
    check("add_rd0_valid", {31'd0, wb_valid}, 32'd1);
    // Bubble.
    bubble();
    tick();
    check("bubble_valid", {31'd0, wb_valid}, 32'd0);
    check("bubble_we", {31'd0, wb_we}, 32'd0);

    // LB at 0x1003, zero-wait ack.
    mem_access(OPC_LOAD, F3_LB, 32'h0000_1003, 32'd0, 5'd7, 0, 32'h80FF_0000,
               st, rc, qa, qw, qb, qe);
    check("lb_stalls", st, 32'd1);
    check("lb_addr", qa, 32'h0000_1000);
    check("lb_be", {28'd0, qb}, 32'd0);
    check("lb_we_bus", {31'd0, qe}, 32'd0);
    check("lb_data", wb_data, 32'hFFFF_FF80);
    check("lb_wb_we", {31'd0, wb_we}, 32'd1);
    check("lb_rd", {27'd0, wb_rd}, 32'd7);
    check("lb_req_drop", {31'd0, u_if.req}, 32'd0);

    // LBU at the same address.
    mem_access(OPC_LOAD, F3_LBU, 32'h0000_1003, 32'd0, 5'd8, 0, 32'h80FF_0000,
               st, rc, qa, qw, qb, qe);
    check("lbu_data", wb_data, 32'h0000_0080);

    // SH at 0x2002.
    mem_access(OPC_STORE, F3_SH, 32'h0000_2002, 32'h0000_ABCD, 5'd3, 0, 32'd0,
               st, rc, qa, qw, qb, qe);
    check("sh_be", {28'd0, qb}, 32'h0000_000C);
    check("sh_wdata", qw, 32'hABCD_ABCD);
    check("sh_we_bus", {31'd0, qe}, 32'd1);
    check("sh_addr", qa, 32'h0000_2000);
    check("sh_wb_we", {31'd0, wb_we}, 32'd0);
    check("sh_wb_valid", {31'd0, wb_valid}, 32'd1);

    // SB at 0x3001 and SW at 0x3004, with a one-cycle ack delay on SB.
    mem_access(OPC_STORE, F3_SB, 32'h0000_3001, 32'h1234_5678, 5'd0, 1, 32'd0,
               st, rc, qa, qw, qb, qe);
    check("sb_be", {28'd0, qb}, 32'h0000_0002);
    check("sb_wdata", qw, 32'h7878_7878);
    check("sb_stalls", st, 32'd2);
    mem_access(OPC_STORE, F3_SW, 32'h0000_3004, 32'hDEAD_BEEF, 5'd0, 0, 32'd0,
               st, rc, qa, qw, qb, qe);
    check("sw_be", {28'd0, qb}, 32'h0000_000F);
    check("sw_wdata", qw, 32'hDEAD_BEEF);

    // Misaligned LW at 0x1002: dropped, no request, no stall.
    mem_access(OPC_LOAD, F3_LW, 32'h0000_1002, 32'd0, 5'd4, 0, 32'd0,
               st, rc, qa, qw, qb, qe);
    check("mis_stalls", st, 32'd0);
    check("mis_req_cycles", rc, 32'd0);
    check("mis_pulse", {31'd0, misalign}, 32'd1);
    check("mis_wb_we", {31'd0, wb_we}, 32'd0);
    check("mis_wb_valid", {31'd0, wb_valid}, 32'd1);
    tick();
    check("mis_pulse_end", {31'd0, misalign}, 32'd0);

    // LW never acked: timeout after MAX_WAIT.
    mem_access(OPC_LOAD, F3_LW, 32'h0000_4000, 32'd0, 5'd6, -1, 32'd0,
               st, rc, qa, qw, qb, qe);
    check("to_stalls", st, 32'd5);
    check("to_bus_err", {31'd0, bus_err}, 32'd1);
    check("to_wb_we", {31'd0, wb_we}, 32'd0);
    check("to_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("to_req", {31'd0, u_if.req}, 32'd0);
    tick();
    check("to_pulse_end", {31'd0, bus_err}, 32'd0);

    // LH at 0x4002 with a 3-cycle ack delay.
    mem_access(OPC_LOAD, F3_LH, 32'h0000_4002, 32'd0, 5'd9, 3, 32'h8001_7FFF,
               st, rc, qa, qw, qb, qe);
    check("lh_stalls", st, 32'd4);
    check("lh_data", wb_data, 32'hFFFF_8001);
    check("lh_err", {30'd0, misalign, bus_err}, 32'd0);

    // LW at 0x5000, 2-cycle delay.
    mem_access(OPC_LOAD, F3_LW, 32'h0000_5000, 32'd0, 5'd10, 2, 32'h1234_5678,
               st, rc, qa, qw, qb, qe);
    check("lw_stalls", st, 32'd3);
    check("lw_data", wb_data, 32'h1234_5678);

    // Reset mid-access, then a late ack that must be ignored.
    set_instr(1'b1, OPC_LOAD, F3_LW, 32'h0000_6000, 32'd0, 5'd11);
    tick();
    check("mid_req_up", {31'd0, u_if.req}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_req", {31'd0, u_if.req}, 32'd0);
    tick();
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    check("mid_rst_wb", {30'd0, wb_valid, wb_we}, 32'd0);
    rst = 1'b0;
    bubble();
    u_if.ack   = 1'b1;
    u_if.rdata = 32'hCAFE_F00D;
    tick();
    u_if.ack = 1'b0;
    check("late_ack_valid", {31'd0, wb_valid}, 32'd0);
    check("late_ack_req", {31'd0, u_if.req}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
